// File: rtl/ws281x_pkg.sv
// Shared types and constants for the WS281x receive path.
package ws281x_pkg;

  typedef enum logic [1:0] {
    ST_RESYNC = 2'd0,
    ST_LOW    = 2'd1,
    ST_HIGH   = 2'd2
  } ws_state_e;

  localparam logic [7:0] HCNT_MAX     = 8'hFF;
  localparam int         PIX_BITS_DEF = 24;

  typedef logic [23:0] pixel_t;

endpackage

// File: rtl/ws281x_sync.sv
// Two-flop synchroniser for the WS281x data pin plus a delay flop for edge detection.
module ws281x_sync
  import ws281x_pkg::*;
(
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic din_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic dly_q, dly_d;

  always_comb begin
    sync1_d = din_i;
    sync2_d = sync1_q;
    dly_d   = sync2_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      dly_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      dly_q   <= dly_d;
    end
  end

  assign level_o = sync2_q;
  assign rise_o  = sync2_q & ~dly_q;
  assign fall_o  = ~sync2_q & dly_q;

endmodule

// File: rtl/ws281x_rx.sv
// WS281x one-wire receiver: pulse-width bit decoding, MSB-first pixel assembly
// and reset-gap (frame end) detection.
module ws281x_rx
  import ws281x_pkg::*;
#(
  parameter int PIX_BITS = PIX_BITS_DEF,
  parameter int LCNT_W   = 16
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                din_i,
  input  logic [7:0]          thr_cnt_i,
  input  logic [LCNT_W-1:0]   rst_cnt_i,
  output logic                bit_vld_o,
  output logic                bit_data_o,
  output logic                pix_vld_o,
  output logic [PIX_BITS-1:0] pix_data_o,
  output logic                frame_end_o,
  output logic                err_o
);

  localparam int BCNT_W = $clog2(PIX_BITS);

  logic level, rise, fall;

  ws281x_sync u_sync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .din_i   (din_i),
    .level_o (level),
    .rise_o  (rise),
    .fall_o  (fall)
  );

  ws_state_e           state_q, state_d;
  logic [LCNT_W-1:0]   lcnt_q, lcnt_d;
  logic [7:0]          hcnt_q, hcnt_d;
  logic [PIX_BITS-1:0] shift_q, shift_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic [PIX_BITS-1:0] pix_data_q, pix_data_d;
  logic                bit_vld_q, bit_vld_d;
  logic                bit_data_q, bit_data_d;
  logic                pix_vld_q, pix_vld_d;
  logic                frame_end_q, frame_end_d;
  logic                err_q, err_d;

  logic [LCNT_W-1:0]   rst_eff;
  logic [LCNT_W-1:0]   lcnt_inc;
  logic [7:0]          hcnt_inc;
  logic                new_bit;
  logic [PIX_BITS-1:0] shift_nxt;

  always_comb begin
    rst_eff   = (rst_cnt_i == '0) ? LCNT_W'(1) : rst_cnt_i;
    lcnt_inc  = (lcnt_q == '1) ? lcnt_q : lcnt_q + LCNT_W'(1);
    hcnt_inc  = (hcnt_q == HCNT_MAX) ? hcnt_q : hcnt_q + 8'd1;
    new_bit   = (hcnt_q >= thr_cnt_i);
    shift_nxt = {shift_q[PIX_BITS-2:0], new_bit};

    state_d     = state_q;
    lcnt_d      = lcnt_q;
    hcnt_d      = hcnt_q;
    shift_d     = shift_q;
    bcnt_d      = bcnt_q;
    pix_data_d  = pix_data_q;
    bit_vld_d   = 1'b0;
    bit_data_d  = 1'b0;
    pix_vld_d   = 1'b0;
    frame_end_d = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      ST_RESYNC: begin
        if (level) begin
          lcnt_d = '0;
        end else begin
          lcnt_d = lcnt_inc;
          if (lcnt_inc >= rst_eff) state_d = ST_LOW;
        end
      end

      ST_LOW: begin
        lcnt_d = lcnt_inc;
        // Pulse only on the crossing so a saturated counter cannot re-trigger.
        if (lcnt_q < rst_eff && lcnt_inc >= rst_eff) begin
          frame_end_d = 1'b1;
          bcnt_d      = '0;
          shift_d     = '0;
        end
        if (rise) begin
          hcnt_d  = 8'd1;
          state_d = ST_HIGH;
        end
      end

      ST_HIGH: begin
        if (fall) begin
          bit_vld_d  = 1'b1;
          bit_data_d = new_bit;
          shift_d    = shift_nxt;
          lcnt_d     = LCNT_W'(1);
          state_d    = ST_LOW;
          if (bcnt_q == BCNT_W'(PIX_BITS - 1)) begin
            pix_data_d = shift_nxt;
            pix_vld_d  = 1'b1;
            bcnt_d     = '0;
          end else begin
            bcnt_d = bcnt_q + BCNT_W'(1);
          end
        end else begin
          hcnt_d = hcnt_inc;
          if (hcnt_inc == HCNT_MAX) begin
            err_d   = 1'b1;
            shift_d = '0;
            bcnt_d  = '0;
            lcnt_d  = '0;
            state_d = ST_RESYNC;
          end
        end
      end

      default: state_d = ST_RESYNC;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_RESYNC;
      lcnt_q      <= '0;
      hcnt_q      <= '0;
      shift_q     <= '0;
      bcnt_q      <= '0;
      pix_data_q  <= '0;
      bit_vld_q   <= 1'b0;
      bit_data_q  <= 1'b0;
      pix_vld_q   <= 1'b0;
      frame_end_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      lcnt_q      <= lcnt_d;
      hcnt_q      <= hcnt_d;
      shift_q     <= shift_d;
      bcnt_q      <= bcnt_d;
      pix_data_q  <= pix_data_d;
      bit_vld_q   <= bit_vld_d;
      bit_data_q  <= bit_data_d;
      pix_vld_q   <= pix_vld_d;
      frame_end_q <= frame_end_d;
      err_q       <= err_d;
    end
  end

  assign bit_vld_o   = bit_vld_q;
  assign bit_data_o  = bit_data_q;
  assign pix_vld_o   = pix_vld_q;
  assign pix_data_o  = pix_data_q;
  assign frame_end_o = frame_end_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_ws281x_rx.sv
// Directed bench for ws281x_rx: pulse-width decoding, pixel assembly, frame gaps,
// saturation error and reset behaviour.
module tb_ws281x_rx;
  import ws281x_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        din_i = 1'b0;
  logic [7:0]  thr_cnt_i = 8'd30;
  logic [15:0] rst_cnt_i = 16'd2500;
  logic        bit_vld_o;
  logic        bit_data_o;
  logic        pix_vld_o;
  logic [23:0] pix_data_o;
  logic        frame_end_o;
  logic        err_o;

  ws281x_rx #(.PIX_BITS(24), .LCNT_W(16)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .din_i       (din_i),
    .thr_cnt_i   (thr_cnt_i),
    .rst_cnt_i   (rst_cnt_i),
    .bit_vld_o   (bit_vld_o),
    .bit_data_o  (bit_data_o),
    .pix_vld_o   (pix_vld_o),
    .pix_data_o  (pix_data_o),
    .frame_end_o (frame_end_o),
    .err_o       (err_o)
  );

  always #10 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  logic   bit_log[$];
  pixel_t pix_log[$];
  int fe_cnt = 0, err_cnt = 0, overlap_cnt = 0;
  int last_pix_cyc = 0, last_fe_cyc = 0, err_cyc = 0;

  // Outputs are observed on the falling edge, half a cycle away from the active edge.
  always @(negedge clk_i) begin
    if (bit_vld_o) bit_log.push_back(bit_data_o);
    if (pix_vld_o) begin
      pix_log.push_back(pix_data_o);
      last_pix_cyc = cyc;
    end
    if (frame_end_o) begin
      fe_cnt++;
      last_fe_cyc = cyc;
    end
    if (err_o) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (frame_end_o && pix_vld_o) overlap_cnt++;
  end

  int check_cnt = 0;
  int pass_cnt  = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got === exp) pass_cnt++;
    else $display("[TB] FAIL %s: observed %0h, expected %0h", tag, got, exp);
  endtask

  task automatic applyStimulus(input int hi, input int lo);
    @(negedge clk_i);
    din_i = 1'b1;
    repeat (hi) @(negedge clk_i);
    din_i = 1'b0;
    repeat (lo) @(negedge clk_i);
  endtask

  task automatic sendBit(input logic b);
    if (b) applyStimulus(40, 22);
    else   applyStimulus(20, 42);
  endtask

  task automatic sendPixel(input pixel_t p);
    for (int i = 23; i >= 0; i--) sendBit(p[i]);
  endtask

  task automatic holdLow(input int n);
    din_i = 1'b0;
    repeat (n) @(negedge clk_i);
  endtask

  task automatic settle();
    @(posedge clk_i);
    #2;
  endtask

  int n_bit, n_pix, n_fe, n_err, rise_cyc;
  logic [9:0] ten_bits;

  initial begin
    ten_bits = 10'b1011001110;

    // Reset state
    rst_n_i = 1'b0;
    repeat (3) @(negedge clk_i);
    checkOutput("reset_flags", {27'd0, bit_vld_o, bit_data_o, pix_vld_o, frame_end_o, err_o}, 32'd0);
    checkOutput("reset_pix", {8'd0, pix_data_o}, 32'd0);
    rst_n_i = 1'b1;

    // Initial resync gap must not report a frame end
    holdLow(2600);
    checkOutput("resync_no_frame_end", fe_cnt, 0);

    // 20-high pulse: bit appears on the 3rd rising edge after the pin falls,
    // i.e. during the 4th clock cycle counting the one in which it fell
    din_i = 1'b1;
    repeat (20) @(negedge clk_i);
    din_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 checkOutput("latency_early", bit_vld_o, 1'b0);
    @(posedge clk_i);
    #1 checkOutput("latency_vld", bit_vld_o, 1'b1);
    checkOutput("latency_data", bit_data_o, 1'b0);
    @(negedge clk_i);
    holdLow(2600);
    settle();
    checkOutput("partial_frame_end", fe_cnt, 1);
    checkOutput("partial_no_pix", pix_log.size(), 0);

    // Single pixel 0xA5C30F
    n_bit = bit_log.size();
    n_pix = pix_log.size();
    sendPixel(24'hA5C30F);
    settle();
    checkOutput("pix1_bits", bit_log.size() - n_bit, 24);
    checkOutput("pix1_count", pix_log.size() - n_pix, 1);
    checkOutput("pix1_data", {8'd0, pix_log[pix_log.size()-1]}, 32'h00A5C30F);
    checkOutput("pix1_hold", {8'd0, pix_data_o}, 32'h00A5C30F);

    // Two pixels then a reset gap
    n_pix = pix_log.size();
    n_fe  = fe_cnt;
    sendPixel(24'h123456);
    sendPixel(24'hFEDCBA);
    holdLow(2600);
    settle();
    checkOutput("pix2_count", pix_log.size() - n_pix, 2);
    checkOutput("pix2_first", {8'd0, pix_log[n_pix]}, 32'h00123456);
    checkOutput("pix2_second", {8'd0, pix_log[n_pix+1]}, 32'h00FEDCBA);
    checkOutput("pix2_frame_end", fe_cnt - n_fe, 1);
    checkOutput("pix2_fe_after_pix", last_fe_cyc > last_pix_cyc, 1'b1);

    // 10 bits discarded by the gap, then a full 0xFFFFFF pixel
    n_pix = pix_log.size();
    n_fe  = fe_cnt;
    for (int i = 9; i >= 0; i--) sendBit(ten_bits[i]);
    holdLow(2600);
    sendPixel(24'hFFFFFF);
    holdLow(50);
    settle();
    checkOutput("discard_frame_end", fe_cnt - n_fe, 1);
    checkOutput("discard_pix_count", pix_log.size() - n_pix, 1);
    checkOutput("discard_pix_data", {8'd0, pix_log[pix_log.size()-1]}, 32'h00FFFFFF);

    // Stuck-high line: error at hcnt 255, then a full resync is needed
    n_bit = bit_log.size();
    n_err = err_cnt;
    @(negedge clk_i);
    rise_cyc = cyc;
    din_i = 1'b1;
    repeat (300) @(negedge clk_i);
    holdLow(100);
    applyStimulus(40, 22);
    settle();
    checkOutput("err_count", err_cnt - n_err, 1);
    checkOutput("err_timing", err_cyc - rise_cyc, 257);
    checkOutput("err_no_bits", bit_log.size() - n_bit, 0);
    @(negedge clk_i);
    holdLow(2600);
    sendBit(1'b1);
    settle();
    checkOutput("resync_bit_count", bit_log.size() - n_bit, 1);
    checkOutput("resync_bit_val", bit_log[bit_log.size()-1], 1'b1);

    // Threshold boundary 29/30 and threshold 0
    n_bit = bit_log.size();
    applyStimulus(29, 42);
    applyStimulus(30, 42);
    thr_cnt_i = 8'd0;
    applyStimulus(2, 42);
    thr_cnt_i = 8'd30;
    settle();
    checkOutput("thr_bit_count", bit_log.size() - n_bit, 3);
    checkOutput("thr_29", bit_log[n_bit], 1'b0);
    checkOutput("thr_30", bit_log[n_bit+1], 1'b1);
    checkOutput("thr_zero", bit_log[n_bit+2], 1'b1);

    // Reset in the middle of a pixel, during a high pulse
    for (int i = 0; i < 5; i++) sendBit(1'b1);
    @(negedge clk_i);
    din_i = 1'b1;
    repeat (10) @(negedge clk_i);
    rst_n_i = 1'b0;
    @(posedge clk_i);
    #1;
    checkOutput("midrst_flags", {27'd0, bit_vld_o, bit_data_o, pix_vld_o, frame_end_o, err_o}, 32'd0);
    checkOutput("midrst_pix", {8'd0, pix_data_o}, 32'd0);
    checkOutput("midrst_state", 32'(dut.state_q), 32'(ST_RESYNC));
    @(negedge clk_i);
    din_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
    n_pix = pix_log.size();
    holdLow(2600);
    sendPixel(24'h0F0F0F);
    holdLow(50);
    settle();
    checkOutput("postrst_pix_count", pix_log.size() - n_pix, 1);
    checkOutput("postrst_pix_data", {8'd0, pix_log[pix_log.size()-1]}, 32'h000F0F0F);

    checkOutput("no_fe_pix_overlap", overlap_cnt, 0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
